sipo_deser: RTL and testbench

Serial-in parallel-out deserializer: the receive end of the team's PISO shift-register link. It collects WIDTH serial bits, qualified by a bit strobe, into a live shift register. Each completed word moves into a one-entry output holding register. The holding register drains to downstream logic through a valid/ready handshake, with overrun detection and a resync input for framing recovery.

---
 rtl/sipo_deser.sv | 105 ++++++++++
 tb/tb_sipo_deser.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deser.sv
// sipo_deser: serial-in parallel-out deserializer with a one-entry holding
// register drained by a valid/ready handshake, sticky overrun flag and a
// resync input that restarts word framing.
module sipo_deser #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sin,
    input  logic                     sin_valid,
    input  logic                     sync,
    output logic [WIDTH-1:0]         shift_q,
    output logic [$clog2(WIDTH)-1:0] bit_cnt,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic                     overrun,
    input  logic                     clr_ovr
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shift_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             overrun_q, overrun_d;

    // Partial-word view after an optional resync, before this edge's bit.
    logic [WIDTH-1:0] shift_base;
    logic [CW-1:0]    cnt_base;
    logic             word_done;
    logic             xfer;

    // State register: shift/collection state plus holding register.
    always_ff @(posedge clk) begin
        // NOTE: all state uses non-blocking assignments so every flop samples
        // pre-edge values, independent of statement order.
        if (!rst) begin
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    // Collection next-state: resync, shift in an accepted bit, detect completion.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        shift_base = sync ? '0 : shift_q;
        cnt_base   = sync ? '0 : bit_cnt_q;
        shift_d    = shift_base;
        bit_cnt_d  = cnt_base;
        word_done  = 1'b0;
        if (sin_valid) begin
            if (MSB_FIRST) begin
                shift_d = {shift_base[WIDTH-2:0], sin};
            end else begin
                shift_d = {sin, shift_base[WIDTH-1:1]};
            end
            if (cnt_base == LAST_BIT) begin
                // A resync zeroes cnt_base, so it can never complete a word.
                word_done = 1'b1;
                bit_cnt_d = '0;
            end else begin
                bit_cnt_d = cnt_base + CW'(1);
            end
        end
    end

    // Holding next-state: load on completion, drain on transfer, flag drops.
    always_comb begin
        xfer         = dout_valid_q & dout_ready;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overrun_d    = overrun_q & ~clr_ovr;
        if (word_done) begin
            if (!dout_valid_q || dout_ready) begin
                // Empty slot, or the held word leaves on this same edge.
                dout_d       = shift_d;
                dout_valid_d = 1'b1;
            end else begin
                // Slot still occupied: new word is lost; a set wins over clear.
                overrun_d = 1'b1;
            end
        end else if (xfer) begin
            dout_valid_d = 1'b0;
        end
    end

    assign bit_cnt    = bit_cnt_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: directed vectors for sipo_deser. A table drives the
// MSB-first instance; hand sequences cover LSB-first, resync and reset.
module tb_sipo_deser;

    logic       clk;
    logic       rst;
    logic       sin;
    logic       sin_valid;
    logic       sync;
    logic       dout_ready;
    logic       clr_ovr;

    logic [7:0] a_shift, b_shift, a_dout, b_dout;
    logic [2:0] a_cnt, b_cnt;
    logic       a_valid, b_valid, a_ovr, b_ovr;

    int n_vec = 0;
    int n_err = 0;

    sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sync(sync),
        .shift_q(a_shift), .bit_cnt(a_cnt), .dout(a_dout), .dout_valid(a_valid),
        .dout_ready(dout_ready), .overrun(a_ovr), .clr_ovr(clr_ovr)
    );

    sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sync(sync),
        .shift_q(b_shift), .bit_cnt(b_cnt), .dout(b_dout), .dout_valid(b_valid),
        .dout_ready(dout_ready), .overrun(b_ovr), .clr_ovr(clr_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic       r, sv, s, sy, rdy, clr;
        logic [7:0] e_shift;
        logic [2:0] e_cnt;
        logic [7:0] e_dout;
        logic       e_valid, e_ovr;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic add(input string tag, input logic r, sv, s, sy, rdy, clr,
                       input logic [7:0] es, input logic [2:0] ec,
                       input logic [7:0] ed, input logic ev, eo);
        vec_t v;
        v.tag = tag; v.r = r; v.sv = sv; v.s = s; v.sy = sy; v.rdy = rdy; v.clr = clr;
        v.e_shift = es; v.e_cnt = ec; v.e_dout = ed; v.e_valid = ev; v.e_ovr = eo;
        vq.push_back(v);
    endtask

    // Drive one edge's inputs, then sample 1 time unit after the edge.
    task automatic step(input logic r, sv, s, sy, rdy, clr);
        rst = r; sin_valid = sv; sin = s; sync = sy; dout_ready = rdy; clr_ovr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte_msb(input logic [7:0] b, input logic rdy);
        for (int i = 7; i >= 0; i--) step(1, 1, b[i], 0, rdy, 0);
    endtask

    initial begin
        logic [7:0] bits;
        rst = 1'b0; sin = 1'b0; sin_valid = 1'b0; sync = 1'b0;
        dout_ready = 1'b0; clr_ovr = 1'b0;

        // ---------------- table: MSB-first instance ----------------
        add("reset", 0,0,0,0,0,0, 8'h00,0, 8'h00,0,0);
        // word 0x50 with dout_ready=1
        add("t1b1", 1,1,0,0,1,0, 8'h00,1, 8'h00,0,0);
        add("t1b2", 1,1,1,0,1,0, 8'h01,2, 8'h00,0,0);
        add("t1b3", 1,1,0,0,1,0, 8'h02,3, 8'h00,0,0);
        add("t1b4", 1,1,1,0,1,0, 8'h05,4, 8'h00,0,0);
        add("t1b5", 1,1,0,0,1,0, 8'h0A,5, 8'h00,0,0);
        add("t1b6", 1,1,0,0,1,0, 8'h14,6, 8'h00,0,0);
        add("t1b7", 1,1,0,0,1,0, 8'h28,7, 8'h00,0,0);
        add("t1b8", 1,1,0,0,1,0, 8'h50,0, 8'h50,1,0);
        add("t1drain", 1,0,0,0,1,0, 8'h50,0, 8'h50,0,0);
        // backpressure: 0xA5 held, 0x3C dropped
        add("t3a1", 1,1,1,0,0,0, 8'hA1,1, 8'h50,0,0);
        add("t3a2", 1,1,0,0,0,0, 8'h42,2, 8'h50,0,0);
        add("t3a3", 1,1,1,0,0,0, 8'h85,3, 8'h50,0,0);
        add("t3a4", 1,1,0,0,0,0, 8'h0A,4, 8'h50,0,0);
        add("t3a5", 1,1,0,0,0,0, 8'h14,5, 8'h50,0,0);
        add("t3a6", 1,1,1,0,0,0, 8'h29,6, 8'h50,0,0);
        add("t3a7", 1,1,0,0,0,0, 8'h52,7, 8'h50,0,0);
        add("t3a8", 1,1,1,0,0,0, 8'hA5,0, 8'hA5,1,0);
        add("t3c1", 1,1,0,0,0,0, 8'h4A,1, 8'hA5,1,0);
        add("t3c2", 1,1,0,0,0,0, 8'h94,2, 8'hA5,1,0);
        add("t3c3", 1,1,1,0,0,0, 8'h29,3, 8'hA5,1,0);
        add("t3c4", 1,1,1,0,0,0, 8'h53,4, 8'hA5,1,0);
        add("t3c5", 1,1,1,0,0,0, 8'hA7,5, 8'hA5,1,0);
        add("t3c6", 1,1,1,0,0,0, 8'h4F,6, 8'hA5,1,0);
        add("t3c7", 1,1,0,0,0,0, 8'h9E,7, 8'hA5,1,0);
        add("t3c8", 1,1,0,0,0,0, 8'h3C,0, 8'hA5,1,1);
        add("t3clr", 1,0,0,0,0,1, 8'h3C,0, 8'hA5,1,0);
        add("t3drain", 1,0,0,0,1,0, 8'h3C,0, 8'hA5,0,0);
        // 0x11 held, transfer on the edge completing 0x22
        add("t4a1", 1,1,0,0,0,0, 8'h78,1, 8'hA5,0,0);
        add("t4a2", 1,1,0,0,0,0, 8'hF0,2, 8'hA5,0,0);
        add("t4a3", 1,1,0,0,0,0, 8'hE0,3, 8'hA5,0,0);
        add("t4a4", 1,1,1,0,0,0, 8'hC1,4, 8'hA5,0,0);
        add("t4a5", 1,1,0,0,0,0, 8'h82,5, 8'hA5,0,0);
        add("t4a6", 1,1,0,0,0,0, 8'h04,6, 8'hA5,0,0);
        add("t4a7", 1,1,0,0,0,0, 8'h08,7, 8'hA5,0,0);
        add("t4a8", 1,1,1,0,0,0, 8'h11,0, 8'h11,1,0);
        add("t4b1", 1,1,0,0,0,0, 8'h22,1, 8'h11,1,0);
        add("t4b2", 1,1,0,0,0,0, 8'h44,2, 8'h11,1,0);
        add("t4b3", 1,1,1,0,0,0, 8'h89,3, 8'h11,1,0);
        add("t4b4", 1,1,0,0,0,0, 8'h12,4, 8'h11,1,0);
        add("t4b5", 1,1,0,0,0,0, 8'h24,5, 8'h11,1,0);
        add("t4b6", 1,1,0,0,0,0, 8'h48,6, 8'h11,1,0);
        add("t4b7", 1,1,1,0,0,0, 8'h91,7, 8'h11,1,0);
        add("t4b8", 1,1,0,0,1,0, 8'h22,0, 8'h22,1,0);
        add("t4drain", 1,0,0,0,1,0, 8'h22,0, 8'h22,0,0);

        foreach (vq[i]) begin
            step(vq[i].r, vq[i].sv, vq[i].s, vq[i].sy, vq[i].rdy, vq[i].clr);
            check({vq[i].tag, ".shift"}, a_shift, vq[i].e_shift);
            check({vq[i].tag, ".cnt"}, {5'd0, a_cnt}, {5'd0, vq[i].e_cnt});
            check({vq[i].tag, ".dout"}, a_dout, vq[i].e_dout);
            check({vq[i].tag, ".valid"}, {7'd0, a_valid}, {7'd0, vq[i].e_valid});
            check({vq[i].tag, ".ovr"}, {7'd0, a_ovr}, {7'd0, vq[i].e_ovr});
        end

        // ---------------- LSB-first, sin_valid toggling ----------------
        step(0, 0, 0, 0, 0, 0);
        bits = 8'b0000_1010;  // bits[i] is the i-th bit sent: 0,1,0,1,0,0,0,0
        for (int i = 0; i < 8; i++) begin
            step(1, 1, bits[i], 0, 1, 0);
            check($sformatf("t2.cnt%0d", i), {5'd0, b_cnt}, 8'((i + 1) % 8));
            if (i < 7) begin
                check($sformatf("t2.pend%0d", i), {7'd0, b_valid}, 8'd0);
                step(1, 0, ~bits[i], 0, 1, 0);  // ignored edge with junk on sin
                check($sformatf("t2.hold%0d", i), {5'd0, b_cnt}, 8'(i + 1));
            end
        end
        check("t2.b_dout", b_dout, 8'h0A);
        check("t2.b_valid", {7'd0, b_valid}, 8'd1);
        check("t2.b_shift", b_shift, 8'h0A);
        check("t2.a_dout", a_dout, 8'h50);

        // ---------------- resync discards a partial word ----------------
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 1, 0);
        check("t5.pre_cnt", {5'd0, a_cnt}, 8'd3);
        step(1, 1, 0, 1, 1, 0);
        check("t5.sync_cnt", {5'd0, a_cnt}, 8'd1);
        check("t5.sync_shift", a_shift, 8'h00);
        bits = 8'b1000_0010;  // 1,0,0,0,0,0,1 sent from bit 7 down to bit 1
        for (int i = 7; i >= 1; i--) begin
            step(1, 1, bits[i], 0, 1, 0);
            if (i > 1) check($sformatf("t5.pend%0d", i), {7'd0, a_valid}, 8'd0);
        end
        check("t5.dout", a_dout, 8'h41);
        check("t5.valid", {7'd0, a_valid}, 8'd1);
        // sync alone clears the partial state but leaves the holding register
        step(1, 1, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        check("t5s.cnt", {5'd0, a_cnt}, 8'd0);
        check("t5s.shift", a_shift, 8'h00);
        check("t5s.dout", a_dout, 8'h41);
        check("t5s.valid", {7'd0, a_valid}, 8'd1);

        // ---------------- reset mid-word with full holding + overrun ----------------
        step(0, 0, 0, 0, 0, 0);
        send_byte_msb(8'h33, 0);
        check("t6.hold", a_dout, 8'h33);
        send_byte_msb(8'h0F, 0);
        check("t6.ovr", {7'd0, a_ovr}, 8'd1);
        for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 0, 0);
        check("t6.cnt5", {5'd0, a_cnt}, 8'd5);
        step(0, 1, 1, 0, 1, 0);
        check("t6.rst_shift", a_shift, 8'h00);
        check("t6.rst_cnt", {5'd0, a_cnt}, 8'd0);
        check("t6.rst_dout", a_dout, 8'h00);
        check("t6.rst_valid", {7'd0, a_valid}, 8'd0);
        check("t6.rst_ovr", {7'd0, a_ovr}, 8'd0);
        check("t6.rst_b_shift", b_shift, 8'h00);
        check("t6.rst_b_dout", b_dout, 8'h00);
        send_byte_msb(8'hFF, 1);
        check("t6.ff_dout", a_dout, 8'hFF);
        check("t6.ff_valid", {7'd0, a_valid}, 8'd1);
        check("t6.ff_ovr", {7'd0, a_ovr}, 8'd0);
        check("t6.ff_cnt", {5'd0, a_cnt}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
